sr_pulse_sequencer: RTL and testbench

- Controller for a bank of WIDTH asynchronous SR latch cells (SET/CLR/Q vectors).
- Two requesters submit single-bit set/clear commands over valid/ready; the block arbitrates round-robin.
- Each granted command becomes a timed pulse on exactly one SET or CLR line, followed by a guard/hold window, and updates a mirror of the expected latch state.
- Guarantees SET and CLR are never asserted simultaneously, and at most one line is high at any time.

---
 rtl/sr_pulse_sequencer.sv | 161 ++++++++++++++++
 tb/tb_sr_pulse_sequencer.sv | 143 ++++++++++++++
 2 files changed

// File: rtl/sr_pulse_sequencer.sv
// rtl/sr_pulse_sequencer.sv - round-robin SET/CLR pulse sequencer for an SR latch bank
// Optional Q readback check enabled by defining SR_SEQ_READBACK_EN.
module sr_pulse_sequencer #(
   parameter int WIDTH     = 2,
   parameter int IDX_W     = 1,
   parameter int PULSE_CYC = 5,
   parameter int HOLD_CYC  = 5
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             a_valid,
   output logic             a_ready,
   input  logic             a_op,
   input  logic [IDX_W-1:0] a_idx,
   input  logic             b_valid,
   output logic             b_ready,
   input  logic             b_op,
   input  logic [IDX_W-1:0] b_idx,
   output logic [WIDTH-1:0] SET,
   output logic [WIDTH-1:0] CLR,
   input  logic [WIDTH-1:0] q_in,
   output logic [WIDTH-1:0] mirror,
   output logic             busy,
   output logic             err,
   output logic [IDX_W-1:0] err_idx,
   input  logic             err_clr
);

   typedef enum logic [1:0] {IDLE, PULSE, HOLD} state_t;

   state_t           state, state_nxt;
   logic [7:0]       cnt, cnt_nxt;
   logic             rr, rr_nxt;
   logic             op_q, op_nxt;
   logic [IDX_W-1:0] idx_q, idx_nxt;
   logic [WIDTH-1:0] set_nxt, clr_nxt, mirror_nxt;
   logic             chk, chk_nxt;
   logic             chk_now;

   // Out-of-range indices decode to all zeros, so they pulse nothing and leave mirror alone.
   function automatic logic [WIDTH-1:0] dec(input logic [IDX_W-1:0] i);
      logic [WIDTH-1:0] v;
      v = '0;
      for (int n = 0; n < WIDTH; n++) begin
         v[n] = (i == IDX_W'(n));
      end
      return v;
   endfunction

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state  <= IDLE;
         cnt    <= '0;
         rr     <= 1'b0;
         op_q   <= 1'b0;
         idx_q  <= '0;
         SET    <= '0;
         CLR    <= '0;
         mirror <= '0;
         chk    <= 1'b0;
      end else begin
         state  <= state_nxt;
         cnt    <= cnt_nxt;
         rr     <= rr_nxt;
         op_q   <= op_nxt;
         idx_q  <= idx_nxt;
         SET    <= set_nxt;
         CLR    <= clr_nxt;
         mirror <= mirror_nxt;
         chk    <= chk_nxt;
      end
   end

   always_comb begin
      state_nxt  = state;
      cnt_nxt    = cnt;
      rr_nxt     = rr;
      op_nxt     = op_q;
      idx_nxt    = idx_q;
      set_nxt    = SET;
      clr_nxt    = CLR;
      mirror_nxt = mirror;
      chk_nxt    = 1'b0;
      a_ready    = 1'b0;
      b_ready    = 1'b0;
      case (state)
         IDLE: begin
            // rr = 0 favours A, rr = 1 favours B when both are valid
            a_ready = a_valid & (~b_valid | ~rr);
            b_ready = b_valid & (~a_valid | rr);
            if (a_ready) begin
               op_nxt  = a_op;
               idx_nxt = a_idx;
               rr_nxt  = 1'b1;
            end else if (b_ready) begin
               op_nxt  = b_op;
               idx_nxt = b_idx;
               rr_nxt  = 1'b0;
            end
            if (a_ready | b_ready) begin
               state_nxt = PULSE;
               cnt_nxt   = '0;
               set_nxt   = op_nxt ? dec(idx_nxt) : '0;
               clr_nxt   = op_nxt ? '0 : dec(idx_nxt);
            end
         end
         PULSE: begin
            if (cnt == 8'(PULSE_CYC - 1)) begin
               set_nxt    = '0;
               clr_nxt    = '0;
               mirror_nxt = (mirror & ~dec(idx_q)) | (dec(idx_q) & {WIDTH{op_q}});
               cnt_nxt    = '0;
               if (HOLD_CYC == 0) begin
                  state_nxt = IDLE;
                  chk_nxt   = 1'b1;
               end else begin
                  state_nxt = HOLD;
               end
            end else begin
               cnt_nxt = cnt + 8'd1;
            end
         end
         HOLD: begin
            if (cnt == 8'(HOLD_CYC - 1)) begin
               state_nxt = IDLE;
               cnt_nxt   = '0;
            end else begin
               cnt_nxt = cnt + 8'd1;
            end
         end
         default: state_nxt = IDLE;
      endcase
   end

   assign busy    = (state != IDLE);
   assign chk_now = chk | ((state == HOLD) && (cnt == 8'(HOLD_CYC - 1)));

`ifdef SR_SEQ_READBACK_EN
   logic mism;
   assign mism = |(dec(idx_q) & (q_in ^ {WIDTH{op_q}}));

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         err     <= 1'b0;
         err_idx <= '0;
      end else if (err_clr) begin
         err     <= 1'b0;
         err_idx <= '0;
      end else if (chk_now && mism && !err) begin
         err     <= 1'b1;
         err_idx <= idx_q;
      end
   end
`else
   logic unused_rb;
   assign unused_rb = ^{q_in, err_clr, chk_now};
   assign err       = 1'b0;
   assign err_idx   = '0;
`endif

endmodule

// File: tb/tb_sr_pulse_sequencer.sv
// tb/tb_sr_pulse_sequencer.sv - randomized bench for sr_pulse_sequencer against a timeline model
module tb_sr_pulse_sequencer;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic       rst_n;
   logic       a0_valid, a0_ready, a0_op, b0_valid, b0_ready, b0_op;
   logic       a0_idx, b0_idx, err0, err_idx0, eclr0, busy0;
   logic [1:0] q0, set0, clr0, mir0;
   logic       a1_valid, a1_ready, a1_op, b1_valid, b1_ready, b1_op;
   logic [1:0] a1_idx, b1_idx, err_idx1;
   logic       err1, eclr1, busy1;
   logic [1:0] q1, set1, clr1, mir1;

   sr_pulse_sequencer #(.WIDTH(2), .IDX_W(1), .PULSE_CYC(5), .HOLD_CYC(5)) dut0 (
      .clk(clk), .rst_n(rst_n),
      .a_valid(a0_valid), .a_ready(a0_ready), .a_op(a0_op), .a_idx(a0_idx),
      .b_valid(b0_valid), .b_ready(b0_ready), .b_op(b0_op), .b_idx(b0_idx),
      .SET(set0), .CLR(clr0), .q_in(q0), .mirror(mir0), .busy(busy0),
      .err(err0), .err_idx(err_idx0), .err_clr(eclr0));

   sr_pulse_sequencer #(.WIDTH(2), .IDX_W(2), .PULSE_CYC(1), .HOLD_CYC(0)) dut1 (
      .clk(clk), .rst_n(rst_n),
      .a_valid(a1_valid), .a_ready(a1_ready), .a_op(a1_op), .a_idx(a1_idx),
      .b_valid(b1_valid), .b_ready(b1_ready), .b_op(b1_op), .b_idx(b1_idx),
      .SET(set1), .CLR(clr1), .q_in(q1), .mirror(mir1), .busy(busy1),
      .err(err1), .err_idx(err_idx1), .err_clr(eclr1));

   int n_err = 0;
   int n_chk = 0;
   int cyc   = 0;

   int pc[2] = '{5, 1};
   int hc[2] = '{5, 0};

   // Timeline model: each accept books absolute cycle windows for pulse, busy and mirror update.
   int         free_at[2], ps[2], pe[2], lidx[2], mir_at[2], mir_bit[2], chk_at[2], erri[2];
   logic       lop[2], rr[2], errv[2], mir_val[2];
   logic [1:0] mirv[2];

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_chk++;
      if (got !== exp) begin
         n_err++;
         $display("FAIL %s cycle=%0d got=%0h expected=%0h", tag, cyc, got, exp);
      end
   endtask

   task automatic model(input int k, input logic rst, input logic av, input logic aop, input int aidx,
                        input logic bv, input logic bop, input int bidx, input logic [1:0] q,
                        input logic eclr, input logic ar, input logic br, input logic [1:0] set,
                        input logic [1:0] clr, input logic [1:0] mir, input logic bsy,
                        input logic e, input int ei);
      int         c;
      logic       bsy_e, ar_e, br_e;
      logic [1:0] line;
      string      p;
      c = cyc;
      p = (k == 0) ? "d0_" : "d1_";
      if (!rst) begin
         free_at[k] = c + 1; ps[k] = -10; pe[k] = -20; mir_at[k] = 32'h7fffffff;
         chk_at[k] = -1; mirv[k] = 2'b00; rr[k] = 1'b0; errv[k] = 1'b0; erri[k] = 0;
         lop[k] = 1'b0; lidx[k] = 0;
         return;
      end
      if (c >= mir_at[k]) begin
         mirv[k][mir_bit[k]] = mir_val[k];
         mir_at[k] = 32'h7fffffff;
      end
      bsy_e = (c < free_at[k]);
      line  = (c >= ps[k] && c <= pe[k] && lidx[k] < 2) ? (2'b01 << lidx[k]) : 2'b00;
      ar_e  = !bsy_e && av && (!bv || rr[k] == 1'b0);
      br_e  = !bsy_e && bv && (!av || rr[k] == 1'b1);
      check({p, "a_ready"}, 32'(ar), 32'(ar_e));
      check({p, "b_ready"}, 32'(br), 32'(br_e));
      check({p, "set"}, 32'(set), 32'(lop[k] ? line : 2'b00));
      check({p, "clr"}, 32'(clr), 32'(lop[k] ? 2'b00 : line));
      check({p, "set_and_clr"}, 32'(set & clr), 32'd0);
      check({p, "mirror"}, 32'(mir), 32'(mirv[k]));
      check({p, "busy"}, 32'(bsy), 32'(bsy_e));
      check({p, "err"}, 32'(e), 32'(errv[k]));
      check({p, "err_idx"}, 32'(ei), 32'(erri[k]));
`ifdef SR_SEQ_READBACK_EN
      if (eclr) begin
         errv[k] = 1'b0; erri[k] = 0;
      end else if (c == chk_at[k] && lidx[k] < 2 && q[lidx[k]] != lop[k] && !errv[k]) begin
         errv[k] = 1'b1; erri[k] = lidx[k];
      end
`else
      if (eclr && q[0]) begin
         errv[k] = 1'b0;
      end
`endif
      if (ar_e || br_e) begin
         lop[k]  = ar_e ? aop : bop;
         lidx[k] = ar_e ? aidx : bidx;
         rr[k]   = ar_e;
         ps[k] = c + 1;
         pe[k] = c + pc[k];
         free_at[k] = c + pc[k] + hc[k] + 1;
         if (lidx[k] < 2) begin
            mir_at[k] = c + pc[k] + 1; mir_bit[k] = lidx[k]; mir_val[k] = lop[k];
         end
         chk_at[k] = (hc[k] > 0) ? c + pc[k] + hc[k] : c + pc[k] + 1;
      end
   endtask

   initial begin
      rst_n = 1'b0;
      {a0_valid, a0_op, a0_idx, b0_valid, b0_op, b0_idx, q0, eclr0} = '0;
      {a1_valid, a1_op, a1_idx, b1_valid, b1_op, b1_idx, q1, eclr1} = '0;
      for (int i = 0; i < 4000; i++) begin
         @(posedge clk);
         #1;
         rst_n = !(i < 3 || (i > 200 && $urandom_range(0, 149) == 0));
         if (i < 40) begin
            a0_valid = 1'b1; a0_op = 1'b1; a0_idx = 1'b0; b0_valid = 1'b0;
         end else if (i < 100) begin
            a0_valid = 1'b1; a0_op = 1'b0; a0_idx = 1'b1;
            b0_valid = 1'b1; b0_op = 1'b1; b0_idx = 1'b1;
         end else begin
            a0_valid = ($urandom_range(0, 3) != 0); a0_op = 1'($urandom); a0_idx = 1'($urandom);
            b0_valid = ($urandom_range(0, 3) != 0); b0_op = 1'($urandom); b0_idx = 1'($urandom);
         end
         q0    = (i < 300) ? 2'b00 : 2'($urandom);
         eclr0 = ($urandom_range(0, 39) == 0);
         a1_valid = ($urandom_range(0, 2) != 0); a1_op = 1'($urandom); a1_idx = 2'($urandom);
         b1_valid = ($urandom_range(0, 2) != 0); b1_op = 1'($urandom); b1_idx = 2'($urandom);
         q1    = 2'($urandom);
         eclr1 = ($urandom_range(0, 39) == 0);
         @(negedge clk);
         model(0, rst_n, a0_valid, a0_op, int'(a0_idx), b0_valid, b0_op, int'(b0_idx), q0, eclr0,
               a0_ready, b0_ready, set0, clr0, mir0, busy0, err0, int'(err_idx0));
         model(1, rst_n, a1_valid, a1_op, int'(a1_idx), b1_valid, b1_op, int'(b1_idx), q1, eclr1,
               a1_ready, b1_ready, set1, clr1, mir1, busy1, err1, int'(err_idx1));
         cyc++;
      end
      $display("Result: errors=%0d of %0d checks", n_err, n_chk);
      $finish;
   end

endmodule
